spmmio_keyboard_fifo2: RTL and testbench

Second-generation memory-mapped keyboard interface on the SP MMIO bus. It queues key events from the scan/PS2 front end in a parametrised pointer-based FIFO. It reports fill level and a sticky overflow flag, supports host flush, and raises a level interrupt on a programmable fill threshold. The keyboard-block control and the 48-bit synthetic key matrix with its enable derivation are retained for the TMS9901 keyboard path.

---
 rtl/spmmio_keyboard_fifo2.sv | 173 +++++++++++++++++
 tb/tb_spmmio_keyboard_fifo2.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmmio_keyboard_fifo2.sv
// Memory-mapped keyboard interface, second generation.
// Key events are queued in a pointer-based FIFO. The block reports the fill
// level and a sticky overflow flag, supports host flush, and raises a level
// interrupt at a programmable fill threshold. The keyboard-block control and
// the 48-bit synthetic key matrix feed the TMS9901 keyboard path.
module spmmio_keyboard_fifo2 #(
   parameter int         FIFO_DEPTH     = 16,
   parameter logic [2:0] KEYBOARD_MODEL = 3'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [0:2]  adr,
   input  logic        cs,
   input  logic [0:3]  sel,
   input  logic        we,
   input  logic [0:31] d,
   output logic [0:31] q,
   input  logic        keypress,
   input  logic        isup,
   input  logic [0:6]  keycode,
   input  logic [0:3]  shift_state,
   output logic        keyboard_block,
   output logic [0:47] synth_key_state,
   output logic        synth_keys_enabled,
   output logic        irq
);

   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // Entry layout: [0] isup, [1:4] shift_state, [5:11] keycode.
   logic [0:11]   mem [FIFO_DEPTH];
   logic [0:11]   head;
   logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [CW-1:0] count, count_n;
   logic          overflow, overflow_n;
   logic [7:0]    threshold, threshold_n;
   logic          irq_en, irq_en_n;
   logic          kb_block_n;
   logic [0:47]   synth_n;
   logic          synth_en_n;
   logic          irq_n;

   logic wr_en, pop_strobe, flush, clr_ovf, full, do_pop, do_push, push_drop;

   assign wr_en      = cs && we;
   assign pop_strobe = cs && !we && (adr == 3'd0);
   assign flush      = wr_en && (adr == 3'd0) && sel[3] && d[31];
   assign clr_ovf    = wr_en && (adr == 3'd0) && sel[3] && d[30];
   assign full       = (count == DEPTH_C);
   assign do_pop     = pop_strobe && (count != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push    = keypress && !flush && (!full || do_pop);
   assign push_drop  = keypress && !flush && full && !do_pop;
   assign head       = mem[rd_ptr];

   // FIFO pointer and fill-level next state; flush overrides push and pop.
   always_comb begin
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count;
      if (flush) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
         count_n  = '0;
      end else begin
         if (do_push) wr_ptr_n = wr_ptr + 1'b1;
         if (do_pop)  rd_ptr_n = rd_ptr + 1'b1;
         if (do_push && !do_pop)      count_n = count + 1'b1;
         else if (!do_push && do_pop) count_n = count - 1'b1;
      end
   end

   // Overflow is sticky; a dropping push beats a same-cycle clear.
   always_comb begin
      overflow_n = overflow;
      if (push_drop)    overflow_n = 1'b1;
      else if (clr_ovf) overflow_n = 1'b0;
   end

   // Register-file writes for matrix, block and interrupt control.
   always_comb begin
      kb_block_n  = keyboard_block;
      synth_n     = synth_key_state;
      synth_en_n  = synth_keys_enabled;
      threshold_n = threshold;
      irq_en_n    = irq_en;
      if (wr_en) begin
         case (adr)
            3'd1: begin
               if (sel[0]) kb_block_n    = d[7];
               if (sel[2]) synth_n[0:7]  = d[16:23];
               if (sel[3]) synth_n[8:15] = d[24:31];
               if (sel[2] || sel[3]) synth_en_n = |synth_n;
            end
            3'd2: begin
               for (int k = 0; k < 4; k++) begin
                  if (sel[k]) synth_n[16 + 8*k +: 8] = d[8*k +: 8];
               end
               synth_en_n = 1'b0;
            end
            3'd3: begin
               if (sel[0]) threshold_n = (d[0:7] == 8'd0) ? 8'd1 : d[0:7];
               if (sel[3]) irq_en_n    = d[31];
            end
            default: ;
         endcase
      end
   end

   // Interrupt tracks the state taking effect on this same edge.
   assign irq_n = irq_en_n && ((8'(count_n) >= threshold_n) || overflow_n);

   // Control state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         overflow           <= 1'b0;
         threshold          <= 8'd1;
         irq_en             <= 1'b0;
         keyboard_block     <= 1'b0;
         synth_key_state    <= '0;
         synth_keys_enabled <= 1'b0;
         irq                <= 1'b0;
      end else begin
         wr_ptr             <= wr_ptr_n;
         rd_ptr             <= rd_ptr_n;
         count              <= count_n;
         overflow           <= overflow_n;
         threshold          <= threshold_n;
         irq_en             <= irq_en_n;
         keyboard_block     <= kb_block_n;
         synth_key_state    <= synth_n;
         synth_keys_enabled <= synth_en_n;
         irq                <= irq_n;
      end
   end

   // Event storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {isup, shift_state, keycode};
   end

   // Combinational read mux.
   always_comb begin
      q = '0;
      case (adr)
         3'd0: begin
            q[0]     = (count != '0);
            q[1:3]   = KEYBOARD_MODEL;
            q[4:7]   = head[1:4];
            q[8]     = head[0];
            q[9:15]  = head[5:11];
            q[16:23] = 8'(count);
            q[24]    = overflow;
         end
         3'd1: begin
            q[7]     = keyboard_block;
            q[16:31] = synth_key_state[0:15];
         end
         3'd2: q = synth_key_state[16:47];
         3'd3: begin
            q[0:7] = threshold;
            q[31]  = irq_en;
         end
         default: q = '0;
      endcase
   end

endmodule

// File: tb/tb_spmmio_keyboard_fifo2.sv
// Scoreboard bench for spmmio_keyboard_fifo2. A queue-based reference model
// produces expected read data and expected registered outputs; a monitor
// compares them against the DUT on the falling clock edge.
module tb_spmmio_keyboard_fifo2;

   localparam int         DEPTH = 16;
   localparam logic [2:0] MODEL = 3'd5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [0:2]  adr;
   logic        cs;
   logic [0:3]  sel;
   logic        we;
   logic [0:31] d;
   logic [0:31] q;
   logic        keypress;
   logic        isup;
   logic [0:6]  keycode;
   logic [0:3]  shift_state;
   logic        keyboard_block;
   logic [0:47] synth_key_state;
   logic        synth_keys_enabled;
   logic        irq;

   spmmio_keyboard_fifo2 #(.FIFO_DEPTH(DEPTH), .KEYBOARD_MODEL(MODEL)) dut (
      .clk(clk), .reset_n(reset_n), .adr(adr), .cs(cs), .sel(sel), .we(we),
      .d(d), .q(q), .keypress(keypress), .isup(isup), .keycode(keycode),
      .shift_state(shift_state), .keyboard_block(keyboard_block),
      .synth_key_state(synth_key_state),
      .synth_keys_enabled(synth_keys_enabled), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct { int at; logic [31:0] v; logic [31:0] m; } rd_t;
   typedef struct { int at; logic irq; logic kb; logic en; logic [47:0] syn; } st_t;

   rd_t rd_q[$];
   st_t st_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;

   // Reference model state (numeric bit order: bit 47 is matrix key 0).
   logic [11:0] fifo[$];
   logic        m_ovf, m_irq_en, m_kb, m_en, m_irq;
   logic [7:0]  m_thr;
   logic [47:0] m_syn;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: read data whenever a read is presented, registered outputs when due.
   always @(negedge clk) begin : mon
      rd_t r;
      st_t s;
      logic [31:0] qv;
      if (reset_n && cs && !we) begin
         qv = q;
         if (rd_q.size() == 0) begin
            chk("read_unexpected", 64'(qv), 64'hDEAD);
         end else begin
            r = rd_q.pop_front();
            chk("read_data", 64'(qv & r.m), 64'(r.v & r.m));
         end
      end
      while (st_q.size() > 0 && st_q[0].at <= cyc) begin
         s = st_q.pop_front();
         chk("irq", 64'(irq), 64'(s.irq));
         chk("keyboard_block", 64'(keyboard_block), 64'(s.kb));
         chk("synth_enabled", 64'(synth_keys_enabled), 64'(s.en));
         chk("synth_state", 64'(synth_key_state), 64'(s.syn));
      end
   end

   task automatic push_state(input int at);
      st_q.push_back('{at: at, irq: m_irq, kb: m_kb, en: m_en, syn: m_syn});
   endtask

   task automatic model_reset();
      fifo.delete();
      m_ovf = 0; m_irq_en = 0; m_kb = 0; m_en = 0; m_irq = 0;
      m_thr = 8'd1; m_syn = '0;
   endtask

   // One bus/keyboard cycle: drive inputs, record expectations, advance model.
   task automatic drive(input logic c, input logic w, input logic [2:0] a,
                        input logic [3:0] s, input logic [31:0] dd,
                        input logic kp, input logic iu,
                        input logic [6:0] kc, input logic [3:0] ss);
      logic [31:0] v, m;
      logic [11:0] h;
      int n;
      logic fl, clr, ovs;
      @(posedge clk);
      #1;
      cs = c; we = w; adr = a; sel = s; d = dd;
      keypress = kp; isup = iu; keycode = kc; shift_state = ss;
      n = fifo.size();
      if (c && !w) begin
         m = '1;
         case (a)
            3'd0: begin
               h = (n > 0) ? fifo[0] : 12'h0;
               v = {n != 0, MODEL, h[10:7], h[11], h[6:0], 8'(n), m_ovf, 7'b0};
               if (n == 0) m = 32'hF000_FFFF;
            end
            3'd1: v = {7'b0, m_kb, 8'b0, m_syn[47:32]};
            3'd2: v = m_syn[31:0];
            3'd3: v = {m_thr, 23'b0, m_irq_en};
            default: v = '0;
         endcase
         rd_q.push_back('{at: cyc, v: v, m: m});
      end
      fl  = c && w && a == 3'd0 && s[0] && dd[0];
      clr = c && w && a == 3'd0 && s[0] && dd[1];
      ovs = 0;
      if (fl) begin
         fifo.delete();
      end else begin
         if (c && !w && a == 3'd0 && n > 0) void'(fifo.pop_front());
         if (kp) begin
            if (fifo.size() < DEPTH) fifo.push_back({iu, ss, kc});
            else ovs = 1;
         end
      end
      if (ovs) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (c && w) begin
         if (a == 3'd1) begin
            if (s[3]) m_kb = dd[24];
            if (s[1]) m_syn[47:40] = dd[15:8];
            if (s[0]) m_syn[39:32] = dd[7:0];
            if (s[1] || s[0]) m_en = |m_syn;
         end else if (a == 3'd2) begin
            for (int j = 0; j < 4; j++) if (s[j]) m_syn[8*j +: 8] = dd[8*j +: 8];
            m_en = 0;
         end else if (a == 3'd3) begin
            if (s[3]) m_thr = (dd[31:24] == 8'd0) ? 8'd1 : dd[31:24];
            if (s[0]) m_irq_en = dd[0];
         end
      end
      m_irq = m_irq_en && ((fifo.size() >= int'(m_thr)) || m_ovf);
      push_state(cyc + 1);
   endtask

   task automatic rd(input logic [2:0] a);
      drive(1, 0, a, 4'hF, 32'h0, 0, 0, 7'h0, 4'h0);
   endtask
   task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] dd);
      drive(1, 1, a, s, dd, 0, 0, 7'h0, 4'h0);
   endtask
   task automatic key(input logic [6:0] kc, input logic iu, input logic [3:0] ss);
      drive(0, 0, 3'd0, 4'h0, 32'h0, 1, iu, kc, ss);
   endtask
   task automatic key_rand();
      key(7'($urandom), 1'($urandom), 4'($urandom));
   endtask
   task automatic idle();
      drive(0, 0, 3'd0, 4'h0, 32'h0, 0, 0, 7'h0, 4'h0);
   endtask

   // Reset asserted mid-cycle with a keypress held across the next edge.
   task automatic mid_reset();
      @(posedge clk);
      #1;
      cs = 0; we = 0; keypress = 0;
      @(negedge clk);
      #1;
      reset_n = 0;
      keypress = 1; isup = 1; keycode = 7'h2A; shift_state = 4'h3;
      model_reset();
      push_state(cyc + 1);
      @(posedge clk);
      #1;
      reset_n = 1;
      keypress = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 0; cs = 0; we = 0; adr = '0; sel = '0; d = '0;
      keypress = 0; isup = 0; keycode = '0; shift_state = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1;
      push_state(cyc);
      rd(3'd3);
      rd(3'd0);

      // Three events, popped in order, then an empty read.
      key(7'h11, 0, 4'h0);
      key(7'h12, 1, 4'h0);
      key(7'h05, 0, 4'b1000);
      repeat (4) rd(3'd0);

      // Overflow: 17 events into 16 slots, then clear.
      repeat (17) key_rand();
      rd(3'd0);
      key_rand();
      wr(3'd0, 4'b0001, 32'h0000_0002);
      repeat (17) rd(3'd0);

      // Full FIFO with simultaneous keypress and pop.
      repeat (16) key_rand();
      drive(1, 0, 3'd0, 4'hF, 32'h0, 1, 1, 7'h7F, 4'hA);
      repeat (17) rd(3'd0);

      // Mixed push/pop across pointer wrap.
      for (int i = 0; i < 40; i++)
         drive(1'($urandom), 0, 3'd0, 4'hF, 32'h0, 1'($urandom), 1'($urandom),
               7'($urandom), 4'($urandom));

      // Threshold interrupt.
      wr(3'd0, 4'b0001, 32'h0000_0001);
      wr(3'd3, 4'b1001, 32'h0400_0001);
      repeat (3) key_rand();
      key_rand();
      rd(3'd0);
      wr(3'd3, 4'b1000, 32'h0);
      rd(3'd3);
      wr(3'd3, 4'b0001, 32'h0);

      // Synthetic matrix and keyboard block.
      wr(3'd2, 4'b1111, 32'h0000_0001);
      wr(3'd1, 4'b0011, 32'h0);
      rd(3'd2);
      wr(3'd2, 4'b1111, 32'h0);
      wr(3'd1, 4'b1000, 32'h0100_0000);
      rd(3'd1);

      // Mid-stream reset, then flush with concurrent keypress.
      repeat (3) key_rand();
      mid_reset();
      rd(3'd0);
      rd(3'd3);
      repeat (2) key_rand();
      drive(1, 1, 3'd0, 4'b0001, 32'h0000_0001, 1, 0, 7'h33, 4'h1);
      rd(3'd0);

      // Randomized traffic over the whole register map.
      for (int i = 0; i < 400; i++) begin
         int op;
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2, 3: drive(1, 0, 3'd0, 4'hF, 32'h0, 1'($urandom), 1'($urandom),
                              7'($urandom), 4'($urandom));
            4: rd(3'($urandom_range(1, 7)));
            5: drive(1, 1, 3'd1, 4'($urandom), $urandom, 1'($urandom), 0, 7'($urandom), 4'h0);
            6: drive(1, 1, 3'd2, 4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
                     1'($urandom), 1, 7'($urandom), 4'h5);
            7: wr(3'd3, 4'($urandom), {8'($urandom_range(0, 20)), 23'b0, 1'($urandom)});
            8: drive(1, 1, 3'd0, 4'($urandom),
                     {30'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0)},
                     1'($urandom), 0, 7'($urandom), 4'($urandom));
            default: drive(0, 1'($urandom), 3'($urandom), 4'($urandom), $urandom,
                           1'($urandom), 0, 7'($urandom), 4'($urandom));
         endcase
      end

      idle();
      idle();
      for (int i = 0; i < 10 && (rd_q.size() > 0 || st_q.size() > 0); i++) @(posedge clk);
      checks++;
      if (rd_q.size() > 0 || st_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending_reads=%0d pending_states=%0d expected 0", rd_q.size(), st_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
